// File: rtl/filter_pkg.sv
// Shared definitions for the 5x5 filter pipeline.
// Pixel width, window geometry and the default line width used by
// line_window_5row and the downstream cascaded FIR.
package filter_pkg;

    localparam int unsigned PIX_W             = 8;
    localparam int unsigned WIN_ROWS          = 5;
    localparam int unsigned LINE_RAMS         = WIN_ROWS - 1;
    localparam int unsigned DEFAULT_IMG_WIDTH = 640;
    localparam int unsigned SEL_W             = $clog2(LINE_RAMS);

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line buffer: one synchronous write port, one synchronous
// read port, single clock. A read and write to the same address in the same
// cycle returns the old contents. The storage array is never reset; only the
// read data register is cleared by rst so downstream muxes start at zero.
//   clk   : clock
//   rst   : asynchronous active-low reset (read register only)
//   we    : write enable          waddr/wdata : write address / data
//   re    : read enable           raddr/rdata : read address / registered data
module line_ram
    import filter_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_IMG_WIDTH,
    parameter int unsigned AW    = $clog2(DEFAULT_IMG_WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pix_t          wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output pix_t          rdata
);

    pix_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_window_5row.sv
// Raster-to-column window generator: turns an 8-bit raster pixel stream into
// five vertically aligned pixels (current row plus four rows above) for the
// cascaded 5x5 FIR. Four line RAMs rotate as the write target per line.
//   clk          : clock
//   rst          : asynchronous active-low reset
//   sof          : start of frame, qualified by pix_in_valid
//   pix_in       : raster-order input pixel
//   pix_in_valid : pix_in / sof valid this cycle
//   pixel0..4    : rows r-4 .. r of the current column
//   out_valid    : pixel0..4 form a complete column
module line_window_5row
    import filter_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = DEFAULT_IMG_WIDTH,
    parameter int unsigned COL_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_in_valid,
    output logic [PIX_W-1:0] pixel0,
    output logic [PIX_W-1:0] pixel1,
    output logic [PIX_W-1:0] pixel2,
    output logic [PIX_W-1:0] pixel3,
    output logic [PIX_W-1:0] pixel4,
    output logic             out_valid
);

    localparam int unsigned      RAM_AW   = $clog2(IMG_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [2:0]       ROW_FULL = 3'(LINE_RAMS);

    logic [COL_W-1:0] col_cnt, col_eff;
    logic [2:0]       row_cnt, row_eff;
    sel_t             wr_sel, sel_eff, rd_sel;
    sel_t             sel1, sel2, sel3;
    logic             sof_go;
    pix_t             pix_q;
    logic             out_valid_q;
    pix_t             rd_data [LINE_RAMS];

    // sof restarts the frame in the same cycle: the qualifying pixel already
    // uses the zeroed counters, so it lands at row 0, column 0.
    always_comb begin
        sof_go  = sof && pix_in_valid;
        col_eff = sof_go ? '0 : col_cnt;
        row_eff = sof_go ? '0 : row_cnt;
        sel_eff = sof_go ? '0 : wr_sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
            wr_sel  <= '0;
        end else if (pix_in_valid) begin
            if (col_eff == LAST_COL) begin
                col_cnt <= '0;
                wr_sel  <= sel_eff + sel_t'(1);
                row_cnt <= (row_eff == ROW_FULL) ? ROW_FULL : row_eff + 3'd1;
            end else begin
                col_cnt <= col_eff + COL_W'(1);
                wr_sel  <= sel_eff;
                row_cnt <= row_eff;
            end
        end
    end

    // rd_sel remembers which RAM held row r-4 for the read now in flight;
    // it and pix_q only move on accepted pixels so outputs hold across gaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_sel      <= '0;
            pix_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= pix_in_valid && (row_eff == ROW_FULL);
            if (pix_in_valid) begin
                rd_sel <= sel_eff;
                pix_q  <= pix_in;
            end
        end
    end

    for (genvar i = 0; i < LINE_RAMS; i++) begin : g_ram
        line_ram #(
            .DEPTH (IMG_WIDTH),
            .AW    (RAM_AW)
        ) u_line_ram (
            .clk   (clk),
            .rst   (rst),
            .we    (pix_in_valid && (sel_eff == sel_t'(i))),
            .waddr (col_eff[RAM_AW-1:0]),
            .wdata (pix_in),
            .re    (pix_in_valid),
            .raddr (col_eff[RAM_AW-1:0]),
            .rdata (rd_data[i])
        );
    end

    // The RAM being overwritten still returns row r-4 (read-before-write);
    // the following RAMs in rotation order hold r-3 .. r-1.
    always_comb begin
        sel1      = rd_sel + sel_t'(1);
        sel2      = rd_sel + sel_t'(2);
        sel3      = rd_sel + sel_t'(3);
        pixel0    = rd_data[rd_sel];
        pixel1    = rd_data[sel1];
        pixel2    = rd_data[sel2];
        pixel3    = rd_data[sel3];
        pixel4    = pix_q;
        out_valid = out_valid_q;
    end

endmodule

// File: doc/line_window_5row.md
Name: line_window_5row

Overview:
- Turns a raster-order 8-bit pixel stream into five vertically aligned pixels per cycle: the current row plus the four rows above it.
- Sits directly upstream of the cascaded 5x5 systolic FIR and drives its `pixel0..pixel4` and `in_valid` inputs.
- Holds four full image lines in rotating line RAMs.
- Asserts `out_valid` only once a complete 5-row column is available.

Parameters:
- IMG_WIDTH, 640, active pixels per line; legal range 5..4096.
- COL_W, 12, column counter width; must satisfy 2^COL_W >= IMG_WIDTH.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- sof  input  1  start of frame; qualifies the pixel presented in the same cycle as row 0, column 0.
- pix_in  input  8  raster-order input pixel.
- pix_in_valid  input  1  pix_in (and sof) valid this cycle.
- pixel0  output  8  pixel from row r-4, same column (top of window).
- pixel1  output  8  row r-3.
- pixel2  output  8  row r-2.
- pixel3  output  8  row r-1.
- pixel4  output  8  row r (current input pixel, delayed).
- out_valid  output  1  pixel0..pixel4 form a valid column.

Behaviour:
- Reset (rst=0, asynchronous): col_cnt=0, row_cnt=0, wr_sel=0, pixel0..4=0, out_valid=0. Line RAM contents are not cleared; they are don't-care until rewritten.
- Accepted pixel: pix_in_valid=1 in a cycle. With pix_in_valid=0 there is no state change, out_valid=0 the next cycle, and pixel0..4 hold.
- Column counter: increments per accepted pixel. At IMG_WIDTH-1 it wraps to 0 and row_cnt increments, saturating at 4.
- Line RAMs: four (L0..L3) of IMG_WIDTH x 8.
  - The accepted pixel is written into L[wr_sel] at address col_cnt.
  - All four are read at col_cnt in the same cycle, read-before-write (old data returned).
  - On column wrap, wr_sel advances modulo 4.
- Row mapping at read:
  - L[wr_sel] = row r-4; L[wr_sel+1] = r-3; L[wr_sel+2] = r-2; L[wr_sel+3] = r-1 (indices modulo 4).
  - The incoming pixel is row r.
  - RAM read is synchronous, so pix_in is registered once to align.
- Latency: exactly 1 cycle from an accepted pixel to the corresponding registered pixel0..4 / out_valid.
- out_valid=1 in cycle t+1 iff a pixel was accepted in cycle t AND row_cnt==4 at acceptance (i.e. frame rows 0..3 are complete).
- sof with pix_in_valid=1:
  - col_cnt, row_cnt, wr_sel are forced to 0 before processing; that pixel is written as row 0, column 0.
  - out_valid=0 for it.
  - A frame in progress is abandoned; no flush.
- sof with pix_in_valid=0: ignored.
- Simultaneous column wrap and sof: sof wins.
- Rows beyond the 5th: row_cnt stays saturated; every accepted pixel produces out_valid=1.
- No backpressure: the downstream FIR always accepts. Gaps in pix_in_valid propagate 1:1 as gaps in out_valid.
- Frame bottom and line-edge padding are out of scope; the downstream block handles border policy.

Decomposition:
- Shared package (filter_pkg): PIX_W=8, WIN_ROWS=5, LINE_RAMS=WIN_ROWS-1, default IMG_WIDTH.
- Sub-module line_ram: simple dual-port, one sync write, one sync read, same clock, read-before-write on address collision, no reset on the array. It is instantiated four times.
- The top level holds the counters, wr_sel, output mux/registers and the valid logic.

Test Plan:
- Rows 0..4 fill, IMG_WIDTH=8, pix_in=row*16+col, continuous valid, sof with the first pixel → out_valid stays 0 for the first 32 pixels. For pixel 0x40 (row 4, col 0), the next cycle gives pixel0..4 = 0x00, 0x10, 0x20, 0x30, 0x40 with out_valid=1.
- Steady state / RAM rotation: row 5, col 3 → pixel0..4 = 0x13, 0x23, 0x33, 0x43, 0x53. Row 9, col 7 → 0x57, 0x67, 0x77, 0x87, 0x97.
- Valid gaps: same stream with pix_in_valid toggled 1,0,0,1 → out_valid mirrors with 1-cycle delay, outputs hold during gaps, values are identical to the continuous run.
- sof mid-frame: assert sof at row 6, col 2 → that pixel becomes row 0. No out_valid until 32 further pixels; the next valid column contains only new-frame data.
- Async reset mid-frame: drop rst at row 5 between clock edges → outputs and out_valid go to 0 immediately without a clock edge. After release, behaviour is identical to a fresh frame.
- Column wrap boundary: IMG_WIDTH=5, last column 4 then col 0 of the next row → wr_sel advances exactly once and pixel3 at the new row's col 0 equals the previous row's col 0.
